// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I memory-stage load/store unit with req/ack bus and timeout abort.
// Define MEM_STAGE_LSU_MISALIGN_EN to trap misaligned/unsupported accesses instead of forcing alignment.
module mem_stage_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        StallM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        misalign
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  localparam logic [CNT_W-1:0] TLIM = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [1:0] state, size, addr_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0] f3_q;
  logic req, unsup, bad, go, timeout;
  logic [3:0] be;
  logic [31:0] wdata, ld;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  assign req = state == IDLE && (MemReadM || MemWriteM);
  assign unsup = funct3M[1:0] == 2'd3 || funct3M == 3'd6;
  assign size = unsup ? 2'd2 : funct3M[1:0];
  assign go = req && !bad;
  assign StallM = reset && (go || state == BUSY);
  // abort fires in the BUSY cycle where the counter would reach TIMEOUT, unless ack arrives
  assign timeout = TIMEOUT != 0 && !bus_ack && cnt == TLIM;
  assign be = size == 2'd0 ? 4'b0001 << Mem_WrAddr[1:0] :
              size == 2'd1 ? (Mem_WrAddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata = size == 2'd0 ? {4{Mem_WrData[7:0]}} :
                 size == 2'd1 ? {2{Mem_WrData[15:0]}} : Mem_WrData;
  assign ld_b = bus_rdata[{addr_q, 3'b000} +: 8];
  assign ld_h = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  assign ld = f3_q == 3'd0 ? {{24{ld_b[7]}}, ld_b} :
              f3_q == 3'd4 ? {24'd0, ld_b} :
              f3_q == 3'd1 ? {{16{ld_h[15]}}, ld_h} :
              f3_q == 3'd5 ? {16'd0, ld_h} : bus_rdata;
`ifdef MEM_STAGE_LSU_MISALIGN_EN
  assign bad = unsup || (size == 2'd1 && Mem_WrAddr[0]) || (size == 2'd2 && Mem_WrAddr[1:0] != 2'd0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) misalign <= 1'b0;
    else misalign <= req && bad;
`else
  assign bad = 1'b0;
  assign misalign = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      f3_q <= '0;
      ReadData <= '0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (state == IDLE) begin
        if (req && bad) ReadData <= '0;
        if (go) begin
          state <= BUSY;
          cnt <= '0;
          addr_q <= Mem_WrAddr[1:0];
          f3_q <= unsup ? 3'd2 : funct3M;
          bus_req <= 1'b1;
          bus_we <= MemWriteM;
          bus_addr <= {Mem_WrAddr[31:2], 2'b00};
          bus_be <= be;
          bus_wdata <= wdata;
        end
      end else if (state == BUSY) begin
        if (!bus_ack) cnt <= cnt + 1'b1;
        if (bus_ack && !bus_we) ReadData <= ld;
        if (bus_ack || timeout) begin
          state <= DONE;
          bus_req <= 1'b0;
        end
        if (timeout) begin
          bus_err <= 1'b1;
          ReadData <= '0;
        end
      end else state <= IDLE;
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed scoreboard bench for mem_stage_lsu.
module tb_mem_stage_lsu;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  st;
    logic [7:0]  rq;
    logic [7:0]  er;
    logic        mis;
  } exp_t;
  logic clk = 0, reset = 1, MemWriteM = 0, MemReadM = 0, bus_ack = 0;
  logic [2:0] funct3M = 0;
  logic [31:0] Mem_WrAddr = 0, Mem_WrData = 0, bus_rdata = 0;
  logic [31:0] ReadData, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic StallM, bus_req, bus_we, bus_err, misalign;
  int checks = 0, errors = 0, ack_after = -1, busy_n = 0, stall_n = 0, req_n = 0, err_n = 0;
  exp_t q[$];
  exp_t cur;

  mem_stage_lsu #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM), .funct3M(funct3M),
    .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData), .ReadData(ReadData), .StallM(StallM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] rd, input int st,
                              input int rq, input int er, input logic mis);
    mk = '{we, addr, be, wd, rd, 8'(st), 8'(rq), 8'(er), mis};
  endfunction

  // bus slave: acks after ack_after wait states (negative = never)
  always @(posedge clk) begin
    #1;
    busy_n = bus_req ? busy_n + 1 : 0;
    bus_ack = bus_req && (busy_n - 1 == ack_after);
  end

  // monitor: bus fields every request cycle, response at DONE or on a misalign pulse
  always @(negedge clk) begin
    if (!reset) begin
      stall_n = 0; req_n = 0; err_n = 0;
    end else begin
      if (StallM) stall_n++;
      if (bus_err) err_n++;
      if (bus_req) begin
        req_n++;
        if (q.size() == 0) chk("bus_req_unexpected", 32'(bus_req), 32'd0);
        else begin
          cur = q[0];
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_be", 32'(bus_be), 32'(cur.be));
          chk("bus_we", 32'(bus_we), 32'(cur.we));
          if (cur.we) chk("bus_wdata", bus_wdata, cur.wd);
        end
      end
      if ((stall_n > 0 && !StallM) || misalign) begin
        if (q.size() == 0) chk("response_unexpected", 32'(misalign), 32'd0);
        else begin
          cur = q.pop_front();
          chk("ReadData", ReadData, cur.rd);
          chk("stall_cycles", 32'(stall_n), 32'(cur.st));
          chk("req_cycles", 32'(req_n), 32'(cur.rq));
          chk("bus_err_cycles", 32'(err_n), 32'(cur.er));
          chk("misalign", 32'(misalign), 32'(cur.mis));
        end
        stall_n = 0; req_n = 0; err_n = 0;
      end
    end
  end

  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] rdat, input int ack, input exp_t e);
    int n;
    ack_after = ack;
    bus_rdata = rdat;
    @(posedge clk); #1;
    q.push_back(e);
    MemWriteM = we; MemReadM = !we; funct3M = f3; Mem_WrAddr = a; Mem_WrData = d;
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); n++; end while (StallM && n < 200);
    checks++;
    if (StallM) begin
      errors++;
      $display("FAIL op_bound: StallM still 1 after %0d cycles, expected 0", n);
    end
    MemWriteM = 0; MemReadM = 0;
  endtask

  initial begin
    #1 reset = 0;
    @(posedge clk); #2;
    chk("rst_ReadData", ReadData, 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_StallM", 32'(StallM), 32'd0);
    @(negedge clk) reset = 1;
    op(1, 3'd0, 32'h1003, 32'h0000_00AB, 32'h0, 0, mk(1, 32'h1000, 4'b1000, 32'hABAB_ABAB, 32'h0, 2, 1, 0, 0));
    op(0, 3'd0, 32'h2001, 32'h0, 32'h0000_F000, 0, mk(0, 32'h2000, 4'b0010, 32'h0, 32'hFFFF_FFF0, 2, 1, 0, 0));
    op(0, 3'd4, 32'h2001, 32'h0, 32'h0000_F000, 0, mk(0, 32'h2000, 4'b0010, 32'h0, 32'h0000_00F0, 2, 1, 0, 0));
    op(0, 3'd1, 32'h2002, 32'h0, 32'h8001_0000, 3, mk(0, 32'h2000, 4'b1100, 32'h0, 32'hFFFF_8001, 5, 4, 0, 0));
    op(1, 3'd1, 32'h1002, 32'h0000_BEEF, 32'h0, 1, mk(1, 32'h1000, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_8001, 3, 2, 0, 0));
    op(1, 3'd2, 32'h1004, 32'hCAFE_F00D, 32'h0, 0, mk(1, 32'h1004, 4'b1111, 32'hCAFE_F00D, 32'hFFFF_8001, 2, 1, 0, 0));
    op(0, 3'd5, 32'h2000, 32'h0, 32'h1234_ABCD, 2, mk(0, 32'h2000, 4'b0011, 32'h0, 32'h0000_ABCD, 4, 3, 0, 0));
    op(0, 3'd0, 32'h2003, 32'h0, 32'h7F00_0000, 0, mk(0, 32'h2000, 4'b1000, 32'h0, 32'h0000_007F, 2, 1, 0, 0));
    op(0, 3'd2, 32'h2008, 32'h0, 32'h5555_5555, -1, mk(0, 32'h2008, 4'b1111, 32'h0, 32'h0, 17, 16, 1, 0));
    op(0, 3'd2, 32'h200C, 32'h0, 32'h1234_5678, 0, mk(0, 32'h200C, 4'b1111, 32'h0, 32'h1234_5678, 2, 1, 0, 0));
    // reset in the second BUSY cycle of a load that is never acked
    ack_after = -1;
    q.push_back(mk(0, 32'h4000, 4'b1111, 32'h0, 32'h0, 0, 0, 0, 0));
    @(posedge clk); #1;
    MemReadM = 1; funct3M = 3'd2; Mem_WrAddr = 32'h4000;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
    reset = 0; #1;
    chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
    chk("mid_rst_StallM", 32'(StallM), 32'd0);
    chk("mid_rst_ReadData", ReadData, 32'd0);
    chk("mid_rst_bus_be", 32'(bus_be), 32'd0);
    @(negedge clk);
    MemReadM = 0;
    q.delete();
    @(negedge clk) reset = 1;
`ifdef MEM_STAGE_LSU_MISALIGN_EN
    op(0, 3'd2, 32'h3002, 32'h0, 32'hDEAD_BEEF, 0, mk(0, 32'h0, 4'b0, 32'h0, 32'h0, 0, 0, 0, 1));
    op(1, 3'd0, 32'h1001, 32'h0000_005A, 32'h0, 0, mk(1, 32'h1000, 4'b0010, 32'h5A5A_5A5A, 32'h0, 2, 1, 0, 0));
    op(0, 3'd3, 32'h2010, 32'h0, 32'hA5A5_A5A5, 0, mk(0, 32'h0, 4'b0, 32'h0, 32'h0, 0, 0, 0, 1));
`else
    op(0, 3'd2, 32'h3002, 32'h0, 32'hDEAD_BEEF, 0, mk(0, 32'h3000, 4'b1111, 32'h0, 32'hDEAD_BEEF, 2, 1, 0, 0));
    op(1, 3'd0, 32'h1001, 32'h0000_005A, 32'h0, 0, mk(1, 32'h1000, 4'b0010, 32'h5A5A_5A5A, 32'hDEAD_BEEF, 2, 1, 0, 0));
    op(0, 3'd3, 32'h2010, 32'h0, 32'hA5A5_A5A5, 0, mk(0, 32'h2010, 4'b1111, 32'h0, 32'hA5A5_A5A5, 2, 1, 0, 0));
`endif
    repeat (4) @(posedge clk);
    #2 chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
